// File: rtl/spi_port_ctrl.sv
// SPI mode-0 slave (oversampled on clk_i) fronting NUM_PORTS output port registers
// and synchronised input port readback, with burst auto-increment and atomic shadow mode.

module spi_port_lane #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic         sh_wr_i,
  input  logic         commit_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] port_o,
  output logic         upd_o
);
  logic [W-1:0] port_q, port_d, shadow_q, shadow_d;
  logic         sv_q, sv_d, upd_q, upd_d;

  always_comb begin
    port_d   = port_q;
    shadow_d = shadow_q;
    sv_d     = sv_q;
    upd_d    = 1'b0;
    if (wr_i) begin
      port_d = data_i;
      upd_d  = 1'b1;
    end
    if (sh_wr_i) begin
      shadow_d = data_i;
      sv_d     = 1'b1;
    end
    // Only ports written during the shadowed frame are committed.
    if (commit_i && sv_q) begin
      port_d = shadow_q;
      upd_d  = 1'b1;
      sv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_q   <= '0;
      shadow_q <= '0;
      sv_q     <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      port_q   <= port_d;
      shadow_q <= shadow_d;
      sv_q     <= sv_d;
      upd_q    <= upd_d;
    end
  end

  assign port_o = port_q;
  assign upd_o  = upd_q;
endmodule

module spi_port_ctrl #(
  parameter int unsigned PORT_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter logic [15:0] ID_VALUE   = 16'hD1C7
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            spi_sclk_i,
  input  logic                            spi_cs_i,
  input  logic                            spi_mosi_i,
  output logic                            spi_miso_o,
  input  logic                            mode_i,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] port_i,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_o,
  output logic [NUM_PORTS-1:0]            port_upd_o,
  output logic                            busy_o
);
  localparam int unsigned RXW = (PORT_WIDTH > 8) ? PORT_WIDTH : 8;
  localparam int unsigned CW  = 5;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  typedef struct packed {
    logic                  wr;
    logic                  sh;
    logic [6:0]            addr;
    logic [PORT_WIDTH-1:0] data;
  } wr_req_t;

  // [1] is the synchronised level, [2] the delayed copy for edge detection.
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] pin_s1_q, pin_s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q   <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      pin_s1_q <= '0;
      pin_s2_q <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], spi_sclk_i};
      cs_q     <= {cs_q[1:0], spi_cs_i};
      mosi_q   <= {mosi_q[0], spi_mosi_i};
      pin_s1_q <= port_i;
      pin_s2_q <= pin_s1_q;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign busy_o    = ~cs_q[2];

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RXW-2:0]        rx_q, rx_d;
  logic [RXW-1:0]        rx_nxt;
  logic                  we_q, we_d, mode_q, mode_d;
  logic [6:0]            addr_q, addr_d, rd_addr;
  logic [PORT_WIDTH-1:0] tx_q, tx_d, rd_data;
  logic                  skip_q, skip_d, miso_q, miso_d;
  wr_req_t               req_q, req_d;
  logic                  commit_q, commit_d;
  logic                  load;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] port_val;

  assign rx_nxt = {rx_q, mosi_q[1]};

  // Loads happen at the command's last bit (address still in the shifter)
  // or at a word's last bit (next address in the burst).
  always_comb begin
    rd_addr = 7'(addr_q + 7'd1);
    if (state_q == CMD) rd_addr = rx_nxt[6:0];
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rd_addr == 7'(k))             rd_data = port_val[k];
      if (rd_addr == 7'(k + NUM_PORTS)) rd_data = pin_s2_q[k];
    end
    if (rd_addr == 7'h7F) rd_data = ID_VALUE[PORT_WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    tx_d     = tx_q;
    skip_d   = skip_q;
    req_d    = '0;
    commit_d = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d = CMD;
        cnt_d   = '0;
        mode_d  = mode_i;
        skip_d  = 1'b0;
        tx_d    = '0;
      end
      CMD: if (sclk_rise) begin
        rx_d  = rx_nxt[RXW-2:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(7)) begin
          state_d = DATA;
          cnt_d   = '0;
          we_d    = rx_nxt[7];
          addr_d  = rx_nxt[6:0];
          load    = 1'b1;
        end
      end
      DATA: if (sclk_rise) begin
        rx_d  = rx_nxt[RXW-2:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PORT_WIDTH - 1)) begin
          cnt_d      = '0;
          addr_d     = 7'(addr_q + 7'd1);
          load       = 1'b1;
          req_d.wr   = we_q & ~mode_q;
          req_d.sh   = we_q & mode_q;
          req_d.addr = addr_q;
          req_d.data = rx_nxt[PORT_WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    // The fall right after a load must not shift: the new MSB is still on the wire.
    if (load) begin
      tx_d   = rd_data;
      skip_d = 1'b1;
    end else if (sclk_fall && state_q != IDLE) begin
      if (skip_q) skip_d = 1'b0;
      else        tx_d   = tx_q << 1;
    end
    if (cs_rise) begin
      state_d  = IDLE;
      commit_d = mode_q & (state_q != IDLE);
    end
    miso_d = (state_q != IDLE) & tx_q[PORT_WIDTH-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      mode_q   <= 1'b0;
      tx_q     <= '0;
      skip_q   <= 1'b0;
      miso_q   <= 1'b0;
      req_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      tx_q     <= tx_d;
      skip_q   <= skip_d;
      miso_q   <= miso_d;
      req_q    <= req_d;
      commit_q <= commit_d;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
    logic hit;
    assign hit = (req_q.addr == 7'(k));
    spi_port_lane #(.W(PORT_WIDTH)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wr_i     (req_q.wr & hit),
      .sh_wr_i  (req_q.sh & hit),
      .commit_i (commit_q),
      .data_i   (req_q.data),
      .port_o   (port_val[k]),
      .upd_o    (port_upd_o[k])
    );
  end

  assign port_o     = port_val;
  assign spi_miso_o = miso_q;
endmodule

// File: tb/tb_spi_port_ctrl.sv
// Directed bench for spi_port_ctrl (8-bit ports, 4 ports): SPI master tasks,
// read scoreboard queue, port_upd_o pulse counters.

module tb_spi_port_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0, cs = 1'b1, mosi = 1'b0, mode = 1'b0;
  logic        miso, busy;
  logic [31:0] pin = 32'hFFFF_FFFF;
  logic [31:0] pout;
  logic [3:0]  upd;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int upd_cnt [4] = '{0, 0, 0, 0};
  logic [7:0] sb [$];

  spi_port_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .spi_sclk_i(sclk), .spi_cs_i(cs),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .mode_i(mode),
    .port_i(pin), .port_o(pout), .port_upd_o(upd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int k = 0; k < 4; k++) if (upd[k]) upd_cnt[k]++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_begin(input logic m);
    @(negedge clk);
    mode = m;
    cs   = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic xfer(input int nbits, input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = tx[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      rx   = {rx[6:0], miso};
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_word(input string tag);
    logic [7:0] rx;
    logic [7:0] exp;
    xfer(8, 8'h00, rx);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
    check(tag, {24'h0, rx}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] rx;
    int base [4];
    int waited;

    repeat (5) @(negedge clk);
    check("rst_port_o", pout, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_upd", {28'h0, upd}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_port_o", pout, 32'h0);

    // ID read
    frame_begin(1'b0);
    check("busy_in_frame", {31'h0, busy}, 32'h1);
    xfer(8, 8'h7F, rx);
    sb.push_back(8'hC7);
    read_word("id_read");
    frame_end();
    check("busy_after_frame", {31'h0, busy}, 32'h0);

    // Mode 0 single write to port 1
    for (int k = 0; k < 4; k++) base[k] = upd_cnt[k];
    frame_begin(1'b0);
    xfer(8, 8'h81, rx);
    xfer(8, 8'hA5, rx);
    check("m0_wr_port_o", pout, 32'h0000_A500);
    check("m0_wr_upd1", upd_cnt[1] - base[1], 1);
    check("m0_wr_upd_other", (upd_cnt[0] - base[0]) + (upd_cnt[2] - base[2]) + (upd_cnt[3] - base[3]), 0);
    frame_end();

    // Mode 0 burst write then burst read
    frame_begin(1'b0);
    xfer(8, 8'h80, rx);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (k + 1));
      xfer(8, d, rx);
      check($sformatf("burst_wr_p%0d", k), {24'h0, pout[8*k +: 8]}, {24'h0, d});
    end
    frame_end();
    check("burst_wr_all", pout, 32'h4433_2211);
    frame_begin(1'b0);
    xfer(8, 8'h00, rx);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
    for (int k = 0; k < 4; k++) read_word($sformatf("burst_rd_%0d", k));
    frame_end();

    // Mode 1 shadowed burst write
    frame_begin(1'b1);
    xfer(8, 8'h80, rx);
    xfer(8, 8'h12, rx);
    xfer(8, 8'h34, rx);
    repeat (6) @(negedge clk);
    check("m1_hold", pout, 32'h4433_2211);
    cs = 1'b1;
    waited = 0;
    while (upd == 4'b0 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    check("m1_commit_upd", {28'h0, upd}, 32'h3);
    check("m1_commit_port_o", pout, 32'h4433_3412);
    @(negedge clk);
    check("m1_upd_one_cycle", {28'h0, upd}, 32'h0);
    repeat (6) @(negedge clk);

    // Input readback and ignored writes
    pin[23:16] = 8'h5A;
    repeat (4) @(negedge clk);
    frame_begin(1'b0);
    xfer(8, 8'h06, rx);
    sb.push_back(8'h5A);
    read_word("port_i_rd");
    frame_end();
    for (int k = 0; k < 4; k++) base[k] = upd_cnt[k];
    frame_begin(1'b0);
    xfer(8, 8'h86, rx);
    xfer(8, 8'hFF, rx);
    frame_end();
    frame_begin(1'b0);
    xfer(8, 8'hA0, rx);
    xfer(8, 8'hFF, rx);
    frame_end();
    check("ro_wr_port_o", pout, 32'h4433_3412);
    check("ro_wr_upd", (upd_cnt[0] - base[0]) + (upd_cnt[1] - base[1]) + (upd_cnt[2] - base[2]) + (upd_cnt[3] - base[3]), 0);

    // Mode 1 with partial trailing word
    for (int k = 0; k < 4; k++) base[k] = upd_cnt[k];
    frame_begin(1'b1);
    xfer(8, 8'h80, rx);
    xfer(8, 8'h77, rx);
    xfer(3, 8'h07, rx);
    frame_end();
    check("partial_port_o", pout, 32'h4433_3477);
    check("partial_upd0", upd_cnt[0] - base[0], 1);
    check("partial_upd1", upd_cnt[1] - base[1], 0);

    // Burst read wrapping from 0x7F
    frame_begin(1'b0);
    xfer(8, 8'h7F, rx);
    sb.push_back(8'hC7); sb.push_back(8'h77);
    read_word("wrap_id");
    read_word("wrap_p0");
    frame_end();
    check("sb_empty", sb.size(), 0);

    // Reset mid-frame
    frame_begin(1'b1);
    xfer(8, 8'h81, rx);
    xfer(4, 8'h0F, rx);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_port_o", pout, 32'h0);
    check("midrst_miso", {31'h0, miso}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_upd", {28'h0, upd}, 32'h0);
    cs = 1'b1;
    sclk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_commit", pout, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_port_ctrl.md
# spi_port_ctrl

Parametrised SPI-controlled port controller: an SPI mode-0 slave, oversampled on the system clock, exposing a small register map of output port registers and synchronised input port readback. Generalises the single 8-bit port controller to NUM_PORTS ports of PORT_WIDTH bits. It adds burst access with address auto-increment and a shadowed mode in which all port writes of a frame are applied atomically. Sits between the chip-level pin wrapper and the mixed-signal port interface.

## Interface
- PORT_WIDTH, 8, bits per port and bits per SPI data word; legal 1..16
- NUM_PORTS, 4, number of output ports and input ports; legal 1..32
- ID_VALUE, 16'hD1C7, value read at address 0x7F, truncated to PORT_WIDTH LSBs
- clk_i  input  1  system clock; all logic on its rising edge
- rst_ni  input  1  reset; asynchronous assert, active-low
- spi_sclk_i  input  1  SPI clock, asynchronous, CPOL=0
- spi_cs_i  input  1  SPI chip select, active-low, asynchronous
- spi_mosi_i  input  1  SPI data in, MSB first
- spi_miso_o  output  1  SPI data out, MSB first
- mode_i  input  1  0 = immediate update, 1 = shadowed/atomic update
- port_i  input  NUM_PORTS*PORT_WIDTH  input ports; port k at bits [k*PORT_WIDTH +: PORT_WIDTH]
- port_o  output  NUM_PORTS*PORT_WIDTH  output port registers, same packing
- port_upd_o  output  NUM_PORTS  one-cycle pulse when port k's port_o value is written
- busy_o  output  1  high while a frame is active (synchronised CS low)

## Operation
- spi_sclk_i, spi_cs_i and spi_mosi_i pass through 2-flop synchronisers. port_i passes through a 2-flop synchroniser bank.
- Edges of synchronised SCLK and CS are detected by comparison with a third, delayed flop.
- Frame: synchronised CS falls. Then an 8-bit command: bit7 = W (1 write, 0 read), bits6:0 = start address. Then any number of PORT_WIDTH-bit data words.
- MOSI is sampled on detected SCLK rising edges.
- State machine: IDLE -> CMD on CS fall. CMD -> DATA after the 8th rise. DATA loops per word. Any state -> IDLE on CS rise.
- mode_i is latched on CS fall and held for the whole frame.
- Address map:
  - 0..NUM_PORTS-1: port_o[k], read/write
  - NUM_PORTS..2*NUM_PORTS-1: synchronised port_i[k-NUM_PORTS], read-only
  - 0x7F: ID, read-only
  - all other addresses read as 0
- Writes to read-only or unmapped addresses are ignored.
- After each completed data word the address increments; 0x7F wraps to 0x00.
- Write, mode 0: port_o[k] and port_upd_o[k] update in the cycle after the final data bit's detected rise.
- Write, mode 1: completed words go to shadow registers. On CS rise, every shadow-written port is copied to port_o in one cycle, with all corresponding port_upd_o bits pulsing together.
- Writing the same port several times in one frame: the last completed word wins.
- Read: the read word is loaded into the TX shift register at the command's 8th rise, and again at each word's final rise. The word's MSB drives spi_miso_o immediately. Subsequent bits shift on detected SCLK falls.
- spi_miso_o is 0 when no frame is active.
- CS rise mid-word: the partial word is discarded; no write for it. In mode 1, completed words of the frame are still committed.
- CS rise mid-command: no access.
- Reset values:
  - port_o = 0, shadow registers = 0, shadow-valid flags = 0
  - port_upd_o = 0, spi_miso_o = 0, busy_o = 0
  - FSM in IDLE
  - synchronisers cleared to 0, except CS synchronisers, which reset to 1
- Reset mid-frame aborts the frame; no commit occurs.

## Timing
- Synchronisation plus edge detection latency: 3 clk_i cycles from a pin edge to its internal event.
- SCLK high and low times must each be at least 4 clk_i cycles, so that f_sclk <= f_clk/8.
- CS-low to first SCLK rise must be at least 4 clk_i cycles.
- Last SCLK fall to CS rise must be at least 4 clk_i cycles.
- MISO changes within 4 clk_i cycles after the SCLK fall pin edge.
- MISO's first bit is valid 4 clk_i cycles after the command's 8th SCLK rise pin edge.
- Mode 0 write: port_o changes 4 clk_i cycles after the final data bit's SCLK rise pin edge.
- Mode 1 commit: port_o changes 4 clk_i cycles after the CS rise pin edge.
- busy_o follows synchronised CS: asserted 3 cycles after the pin falls, deasserted 3 cycles after it rises.
- port_i readback reflects the pin value from at least 2 cycles before the word is loaded.

## Test plan
- Reset with port_i = 0xFF on all ports -> port_o = 0, spi_miso_o = 0, busy_o = 0, port_upd_o = 0; read 0x7F -> 0xC7 (PORT_WIDTH = 8).
- Mode 0, write cmd 0x81, data 0xA5 -> port_o[1] = 0xA5, with a single port_upd_o[1] pulse before CS rises; other ports unchanged.
- Mode 0, burst write cmd 0x80, data 0x11, 0x22, 0x33, 0x44 -> ports 0..3 = 0x11..0x44 on successive words. Then read cmd 0x00 with four words -> MISO returns 0x11, 0x22, 0x33, 0x44.
- Mode 1, burst write 0x12, 0x34 to ports 0 and 1 -> port_o unchanged until CS rise. Then both update in the same cycle, with port_upd_o = 0b0011 for one cycle.
- Drive port_i[2] = 0x5A and read cmd 0x06 (NUM_PORTS = 4) -> 0x5A. Write 0xFF to 0x06 and to 0x20 -> no port_o change and no port_upd_o pulse.
- Boundary cases:
  - Mode 1 write of 0x77 to port 0, then a partial second word (3 bits) and CS rise -> only port 0 = 0x77 commits.
  - Burst read starting at 0x7F -> ID, then the 0x00 value.
  - rst_ni low mid-frame -> all outputs return to reset values.
